mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 Instr  input  20  instruction bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
REQ-005 ALUFlags  input  4  datapath ALU flags {N,Z,C,V}, valid in execute states.
REQ-006 PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc  output  1 each  datapath strobes/selects.
REQ-007 RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl  output  2 each  datapath mux selects and ALU operation.
REQ-008 CycleCount, InstrCount  output  32 each  performance counters (REQ-030).

Function
REQ-009 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
REQ-010 FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=00, PCWrite=1; next DECODE.
REQ-011 DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10; Op=01->MEMADR; Op=00 & Funct[5]=0->EXECUTER; Op=00 & Funct[5]=1->EXECUTEI; Op=10->BRANCH; Op=11->FETCH with no writes.
REQ-012 MEMADR: ALUSrcA=00, ALUSrcB=01, ALUControl=00; Funct[0]=1->MEMREAD else MEMWRITE.
REQ-013 MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB. MEMWB: ResultSrc=01, RegWrite -> FETCH.
REQ-014 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite -> FETCH.
REQ-015 EXECUTER: ALUSrcA=00, ALUSrcB=00, decoded ALUControl -> ALUWB; EXECUTEI identical except ALUSrcB=01.
REQ-016 ALUWB: ResultSrc=00, RegWrite -> FETCH.
REQ-017 BRANCH: ALUSrcA=10, ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite -> FETCH.
REQ-018 Latency: LDR 5, STR 4, data-processing 4, B 3, Op=11 2 cycles.
REQ-019 ALU decode (execute states only): cmd Funct[4:1] 0100->00 ADD, 0010->01 SUB, 0000->10 AND, 1100->11 ORR, 1010 (CMP)->01 with RegWrite suppressed; other cmd->00, no flag update.
REQ-020 ImmSrc=Op; RegSrc[0]=(Op==10), RegSrc[1]=(Op==01); both held stable from DECODE through instruction end.
REQ-021 Flags register {N,Z,C,V}: updated at end of EXECUTER/EXECUTEI only when Funct[0]=1 and cond_ok=1; ADD/SUB/CMP update all four, AND/ORR update N,Z only.
REQ-022 cond_ok register SHALL latch Cond evaluated against the flags register at end of DECODE; Cond=1110 and 1111 always true; standard ARM EQ..LE otherwise.
REQ-023 RegWrite, MemWrite and the BRANCH/writeback PCWrite SHALL be gated by cond_ok; FETCH PCWrite/IRWrite ungated.
REQ-024 Rd=1111 with RegWrite asserted in ALUWB/MEMWB SHALL also assert PCWrite (gated by cond_ok).
REQ-025 Flags updated by an instruction SHALL NOT affect that instruction's own writes (cond_ok already latched).

Reset
REQ-026 reset SHALL force state FETCH, flags 0000, cond_ok 0, counters 0 immediately, including mid-instruction.
REQ-027 During reset all strobes (PCWrite, MemWrite, RegWrite, IRWrite) SHALL be 0; selects 00.
REQ-028 First rising edge after reset deassertion SHALL execute FETCH.

Configuration
REQ-029 Macro MC_CTRL_PERF_EN SHALL gate the performance counters.
REQ-030 Defined: CycleCount +1 every cycle out of reset; InstrCount +1 on every transition into FETCH from a terminal state; both wrap 0xFFFFFFFF->0. Undefined: both outputs tied to 0, no counter flops.

Structure
REQ-031 Package mc_ctrl_pkg SHALL hold the state enum, Op encodings, ALUControl codes, cmd codes and Cond codes.
REQ-032 Sub-module mc_condlogic SHALL own the flags register, Cond evaluation and cond_ok register; FSM and decode stay in mc_controller.

Verification
REQ-033 Reset mid-MEMWRITE -> MemWrite drops to 0 asynchronously, state FETCH, flags 0000.
REQ-034 ADD R1,R2,#5 (Instr[31:12]=0xE2821) -> FETCH,DECODE,EXECUTEI,ALUWB; RegWrite=1 in cycle 4, ALUControl=00 in cycle 3.
REQ-035 CMP with ALUFlags=0100 then BNE -> Z latched, BNE cond_ok=0, BRANCH asserts PCWrite=0, 3 cycles.
REQ-036 LDR then STR -> LDR 5 cycles with RegWrite only in MEMWB; STR 4 cycles with MemWrite only in MEMWRITE.
REQ-037 SUBS to Rd=15 with Cond=1110 -> PCWrite and RegWrite both 1 in ALUWB; flags updated end of EXECUTER.
REQ-038 MC_CTRL_PERF_EN defined, 10 cycles of ADD stream after reset -> CycleCount=10, InstrCount=2; undefined -> both 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg -- shared definitions for the multicycle controller.
//   state_t      : FSM state encoding
//   OP_*         : Instr Op field encodings
//   ALU_*        : ALUControl codes driven to the datapath
//   CMD_*        : data-processing cmd field (Funct[4:1]) codes
//   COND_*       : condition field codes
//   cond_eval()  : evaluates a Cond field against a {N,Z,C,V} flag vector
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [1:0] OP_DP   = 2'b00;
    localparam logic [1:0] OP_MEM  = 2'b01;
    localparam logic [1:0] OP_BR   = 2'b10;
    localparam logic [1:0] OP_NONE = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // flags = {N,Z,C,V}; AL and the 1111 encoding are both unconditional
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        logic res;
        {n, z, c, v} = flags;
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mc_condlogic.sv
// mc_condlogic -- flags register and condition evaluation.
//   clk, rst      : clock, asynchronous active-high reset
//   cond          : Cond field of the current instruction
//   alu_flags     : {N,Z,C,V} from the datapath ALU
//   cond_latch    : high in DECODE; cond_ok captures the evaluation at its end
//   flags_upd_nz  : request to update N,Z at end of this cycle
//   flags_upd_cv  : request to update C,V at end of this cycle
//   cond_ok       : latched condition result for the instruction in flight
// Flag update requests are qualified here by cond_ok, so a failed-condition
// instruction never alters the flags.
import mc_ctrl_pkg::*;

module mc_condlogic (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       cond_latch,
    input  logic       flags_upd_nz,
    input  logic       flags_upd_cv,
    output logic       cond_ok
);

    logic [3:0] flags_q, flags_d;
    logic       cond_ok_q, cond_ok_d;

    always_comb begin
        flags_d   = flags_q;
        cond_ok_d = cond_ok_q;
        if (cond_latch) begin
            cond_ok_d = cond_eval(cond, flags_q);
        end
        if (flags_upd_nz && cond_ok_q) begin
            flags_d[3:2] = alu_flags[3:2];
        end
        if (flags_upd_cv && cond_ok_q) begin
            flags_d[1:0] = alu_flags[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q   <= '0;
            cond_ok_q <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cond_ok_q <= cond_ok_d;
        end
    end

    assign cond_ok = cond_ok_q;

endmodule

// File: rtl/mc_controller.sv
// mc_controller -- multicycle ARM-subset control unit (Moore FSM).
//   clk, reset          : clock, asynchronous active-high reset
//   Instr[19:0]         : instruction bits [31:12] (Cond, Op, Funct, Rn, Rd)
//   ALUFlags[3:0]       : {N,Z,C,V} from the ALU, valid in execute states
//   PCWrite .. AdrSrc   : datapath strobes/selects
//   RegSrc .. ALUControl: datapath mux selects and ALU operation
//   CycleCount          : cycles since reset (MC_CTRL_PERF_EN builds only)
//   InstrCount          : instructions completed (MC_CTRL_PERF_EN builds only)
// Build option: define MC_CTRL_PERF_EN to include the performance counters;
// otherwise both counter outputs are tied to zero.
import mc_ctrl_pkg::*;

module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl,
    output logic [31:0] CycleCount,
    output logic [31:0] InstrCount
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       rd_is_pc;
    logic       unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign cmd       = funct[4:1];
    assign rd_is_pc  = (Instr[3:0] == 4'b1111);
    assign unused_rn = ^Instr[7:4];

    state_t state_q, state_d;
    logic   cond_ok;

    // ALU operation decode for the execute states
    logic [1:0] alu_ctrl_dec;
    logic       cmd_known;
    logic       cmd_arith;
    logic       is_cmp;

    always_comb begin
        alu_ctrl_dec = ALU_ADD;
        cmd_known    = 1'b1;
        cmd_arith    = 1'b0;
        is_cmp       = 1'b0;
        case (cmd)
            CMD_ADD: begin alu_ctrl_dec = ALU_ADD; cmd_arith = 1'b1; end
            CMD_SUB: begin alu_ctrl_dec = ALU_SUB; cmd_arith = 1'b1; end
            CMD_AND: alu_ctrl_dec = ALU_AND;
            CMD_ORR: alu_ctrl_dec = ALU_ORR;
            CMD_CMP: begin alu_ctrl_dec = ALU_SUB; cmd_arith = 1'b1; is_cmp = 1'b1; end
            default: cmd_known = 1'b0;
        endcase
    end

    logic in_exec;
    logic flags_upd_nz;
    logic flags_upd_cv;

    assign in_exec      = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);
    assign flags_upd_nz = in_exec && funct[0] && cmd_known;
    assign flags_upd_cv = flags_upd_nz && cmd_arith;

    mc_condlogic u_condlogic (
        .clk          (clk),
        .rst          (reset),
        .cond         (cond),
        .alu_flags    (ALUFlags),
        .cond_latch   (state_q == S_DECODE),
        .flags_upd_nz (flags_upd_nz),
        .flags_upd_cv (flags_upd_cv),
        .cond_ok      (cond_ok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = ALU_ADD;
        ImmSrc     = op;
        RegSrc     = {(op == OP_MEM), (op == OP_BR)};

        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ok;
                PCWrite   = cond_ok && rd_is_pc;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ok;
                state_d  = S_FETCH;
            end
            S_EXECUTER: begin
                ALUControl = alu_ctrl_dec;
                state_d    = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_ctrl_dec;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = cond_ok && !is_cmp;
                PCWrite  = cond_ok && !is_cmp && rd_is_pc;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ok;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // The state register already sits in FETCH while reset is held, so the
        // outputs are forced quiet combinationally rather than relying on state.
        if (reset) begin
            PCWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            IRWrite    = 1'b0;
            AdrSrc     = 1'b0;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ResultSrc  = 2'b00;
            ALUControl = 2'b00;
            ImmSrc     = 2'b00;
            RegSrc     = 2'b00;
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic        instr_done;

    // Every non-FETCH state that can step to FETCH is an instruction's last cycle
    assign instr_done = (state_q != S_FETCH) && (state_d == S_FETCH);

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        instr_cnt_d = instr_cnt_q;
        if (instr_done) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign CycleCount = cycle_cnt_q;
    assign InstrCount = instr_cnt_q;
`else
    assign CycleCount = '0;
    assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller -- directed bench for mc_controller.
// Outputs are packed as {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,
// ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl} and compared per cycle
// against hand-written vectors.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
    logic [31:0] CycleCount, InstrCount;
    logic [16:0] outs;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .CycleCount (CycleCount),
        .InstrCount (InstrCount)
    );

    assign outs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
                   RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Check outputs of the current cycle, then advance to the next negedge.
    task automatic cyc(input string tag, input logic [16:0] exp);
        #1;
        check(tag, {15'b0, outs}, {15'b0, exp});
        @(negedge clk);
    endtask

    // Data-processing FETCH/DECODE (Op=00)
    localparam logic [16:0] F_DP  = 17'b1_0_0_1_0_00_01_10_10_00_00;
    localparam logic [16:0] D_DP  = 17'b0_0_0_0_0_00_01_10_10_00_00;
    localparam logic [16:0] EI_ADD = 17'b0_0_0_0_0_00_00_01_00_00_00;
    localparam logic [16:0] ER_SUB = 17'b0_0_0_0_0_00_00_00_00_00_01;
    localparam logic [16:0] WB_RW = 17'b0_0_1_0_0_00_00_00_00_00_00;
    localparam logic [16:0] WB_PC = 17'b1_0_1_0_0_00_00_00_00_00_00;
    localparam logic [16:0] ZERO  = 17'b0;
    // Branch (Op=10)
    localparam logic [16:0] F_BR  = 17'b1_0_0_1_0_01_01_10_10_10_00;
    localparam logic [16:0] D_BR  = 17'b0_0_0_0_0_01_01_10_10_10_00;
    localparam logic [16:0] BR_NT = 17'b0_0_0_0_0_01_10_01_10_10_00;
    localparam logic [16:0] BR_T  = 17'b1_0_0_0_0_01_10_01_10_10_00;
    // Memory (Op=01)
    localparam logic [16:0] F_MEM = 17'b1_0_0_1_0_10_01_10_10_01_00;
    localparam logic [16:0] D_MEM = 17'b0_0_0_0_0_10_01_10_10_01_00;
    localparam logic [16:0] MADR  = 17'b0_0_0_0_0_10_00_01_00_01_00;
    localparam logic [16:0] MRD   = 17'b0_0_0_0_1_10_00_00_00_01_00;
    localparam logic [16:0] MWB   = 17'b0_0_1_0_0_10_00_00_01_01_00;
    localparam logic [16:0] MWR   = 17'b0_1_0_0_1_10_00_00_00_01_00;
    // Op=11
    localparam logic [16:0] F_NO  = 17'b1_0_0_1_0_00_01_10_10_11_00;
    localparam logic [16:0] D_NO  = 17'b0_0_0_0_0_00_01_10_10_11_00;

    localparam logic [19:0] I_ADD  = 20'hE2821;
    localparam logic [19:0] I_CMP  = 20'hE1510;
    localparam logic [19:0] I_BNE  = 20'h1A000;
    localparam logic [19:0] I_BEQ  = 20'h0A000;
    localparam logic [19:0] I_LDR  = 20'hE5923;
    localparam logic [19:0] I_STR  = 20'hE5823;
    localparam logic [19:0] I_NOP  = 20'hEC000;
    localparam logic [19:0] I_SUBS = 20'hE051F;
    localparam logic [19:0] I_BMI  = 20'h4A000;
    localparam logic [19:0] I_BLT  = 20'hBA000;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_cyc, exp_ins;
        reset    = 1'b1;
        Instr    = I_ADD;
        ALUFlags = 4'b0000;
        #2;
        check("reset_outs", {15'b0, outs}, 32'd0);
        check("reset_cyc", CycleCount, 32'd0);
        check("reset_ins", InstrCount, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ADD stream straight out of reset; counters sampled after 10 edges
        cyc("add1_f", F_DP);  cyc("add1_d", D_DP);  cyc("add1_ei", EI_ADD); cyc("add1_wb", WB_RW);
        cyc("add2_f", F_DP);  cyc("add2_d", D_DP);  cyc("add2_ei", EI_ADD); cyc("add2_wb", WB_RW);
        cyc("add3_f", F_DP);  cyc("add3_d", D_DP);
`ifdef MC_CTRL_PERF_EN
        exp_cyc = 32'd10;
        exp_ins = 32'd2;
`else
        exp_cyc = 32'd0;
        exp_ins = 32'd0;
`endif
        #1;
        check("perf_cyc", CycleCount, exp_cyc);
        check("perf_ins", InstrCount, exp_ins);
        cyc("add3_ei", EI_ADD); cyc("add3_wb", WB_RW);

        // CMP sets Z; BNE not taken, BEQ taken
        Instr = I_CMP; ALUFlags = 4'b0100;
        cyc("cmp_f", F_DP); cyc("cmp_d", D_DP); cyc("cmp_er", ER_SUB); cyc("cmp_wb", ZERO);
        Instr = I_BNE; ALUFlags = 4'b0000;
        cyc("bne_f", F_BR); cyc("bne_d", D_BR); cyc("bne_br", BR_NT);
        Instr = I_BEQ;
        cyc("beq_f", F_BR); cyc("beq_d", D_BR); cyc("beq_br", BR_T);

        // LDR 5 cycles, STR 4 cycles
        Instr = I_LDR;
        cyc("ldr_f", F_MEM); cyc("ldr_d", D_MEM); cyc("ldr_ma", MADR); cyc("ldr_mr", MRD); cyc("ldr_wb", MWB);
        Instr = I_STR;
        cyc("str_f", F_MEM); cyc("str_d", D_MEM); cyc("str_ma", MADR); cyc("str_mw", MWR);

        // Op=11: two cycles, no writes
        Instr = I_NOP;
        cyc("nop_f", F_NO); cyc("nop_d", D_NO);

        // SUBS to R15: PC and register written; flags {1,0,1,1} take effect
        Instr = I_SUBS; ALUFlags = 4'b1011;
        cyc("subs_f", F_DP); cyc("subs_d", D_DP); cyc("subs_er", ER_SUB); cyc("subs_wb", WB_PC);
        Instr = I_BMI; ALUFlags = 4'b0000;
        cyc("bmi_f", F_BR); cyc("bmi_d", D_BR); cyc("bmi_br", BR_T);
        Instr = I_BLT;
        cyc("blt_f", F_BR); cyc("blt_d", D_BR); cyc("blt_br", BR_NT);

        // Reset asserted mid-MEMWRITE
        Instr = I_STR;
        cyc("str2_f", F_MEM); cyc("str2_d", D_MEM); cyc("str2_ma", MADR);
        #1;
        check("str2_mw", {15'b0, outs}, {15'b0, MWR});
        #1;
        reset = 1'b1;
        #1;
        check("rst_mw_memwrite", {31'b0, MemWrite}, 32'd0);
        check("rst_mw_outs", {15'b0, outs}, 32'd0);
        check("rst_mw_cyc", CycleCount, 32'd0);
        check("rst_mw_ins", InstrCount, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        // Flags cleared: BMI must now fail
        Instr = I_BMI;
        cyc("bmi2_f", F_BR); cyc("bmi2_d", D_BR); cyc("bmi2_br", BR_NT);
        Instr = I_ADD;
        cyc("add4_f", F_DP);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
